// File: rtl/noc_rx_depacketizer_pkg.sv
// Flit and credit field layout shared by the NoC receive endpoint.
// Package noc_flit_pkg; also holds the reassembly FSM state type.
package noc_flit_pkg;
  localparam int FLIT_W   = 73;
  localparam int CREDIT_W = 3;

  localparam int VALID_BIT = 72;
  localparam int TAIL_BIT  = 71;
  localparam int DEST_MSB  = 70;
  localparam int DEST_LSB  = 66;
  localparam int VC_MSB    = 65;
  localparam int VC_LSB    = 64;
  localparam int DATA_MSB  = 63;
  localparam int DATA_LSB  = 0;

  localparam int CREDIT_VALID_BIT = 2;
  localparam int CREDIT_VC_MSB    = 1;
  localparam int CREDIT_VC_LSB    = 0;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DROP    = 2'd2
  } rx_state_t;
endpackage

// File: rtl/noc_rx_depacketizer_if.sv
// Reassembled-packet handshake between the depacketizer and the hashing core.
interface noc_rx_depacketizer_if #(
  parameter int DATA_W    = 64,
  parameter int MAX_FLITS = 12,
  parameter int LEN_W     = 4
);
  logic [MAX_FLITS*DATA_W-1:0] pkt_data;
  logic [LEN_W-1:0]            pkt_len;
  logic                        pkt_valid;
  logic                        pkt_ready;

  modport master (output pkt_data, pkt_len, pkt_valid, input pkt_ready);
  modport slave  (input pkt_data, pkt_len, pkt_valid, output pkt_ready);
endinterface

// File: rtl/noc_rx_depacketizer_fifo.sv
// Flit buffer: synchronous FIFO with a registered, first-word-fall-through head.
module noc_flit_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rd_ptr_next = pop_ok ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
  assign dout  = dout_reg;
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // The head register always tracks the next head; a word written straight
  // into that slot is bypassed so it is visible one cycle after the push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
      dout_reg   <= (push_ok && (wr_ptr_reg == rd_ptr_next)) ? din : mem[rd_ptr_next];
    end
  end
endmodule

// File: rtl/noc_rx_depacketizer.sv
// NoC receive endpoint: buffers flits, returns credits, reassembles packets.
// Optional destination filtering is enabled with NOC_RX_DEST_CHECK_EN.
module noc_rx_depacketizer
  import noc_flit_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MAX_FLITS  = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int VC_W       = 2
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [FLIT_W-1:0]     flit_in,
  output logic                  send_credit,
  output logic [CREDIT_W-1:0]   credit_out,
  input  logic [4:0]            processor_id,
  noc_rx_depacketizer_if.master pkt_if,
  output logic                  err_overflow,
  output logic                  err_oversize,
  output logic                  err_misroute
);
  localparam int LEN_W  = $clog2(MAX_FLITS + 1);
  localparam int WORD_W = 2 + 5 + VC_W + DATA_W;

  logic [WORD_W-1:0]               head;
  logic                            fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
  rx_state_t                       state_reg;
  logic [LEN_W-1:0]                cnt_reg, pkt_len_reg;
  logic                            pkt_valid_reg;
  logic                            flit_valid, pop, head_tail, dest_ok, slot_we;
  logic [VC_W-1:0]                 head_vc;
  logic                            unused_bits;

  assign flit_valid = flit_in[VALID_BIT];
  assign head_tail  = head[TAIL_BIT];
  assign head_vc    = head[VC_MSB:VC_LSB];
  assign pop        = !fifo_empty && (state_reg == COLLECT || state_reg == DROP);

`ifdef NOC_RX_DEST_CHECK_EN
  assign dest_ok     = (head[DEST_MSB:DEST_LSB] == processor_id);
  assign unused_bits = ^{head[VALID_BIT], fifo_count};
`else
  assign dest_ok     = 1'b1;
  assign unused_bits = ^{processor_id, head[DEST_MSB:DEST_LSB], head[VALID_BIT], fifo_count};
`endif

  assign slot_we = pop && (state_reg == COLLECT) && dest_ok;

  noc_flit_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst   (reset),
    .push  (flit_valid),
    .pop   (pop),
    .din   (flit_in[WORD_W-1:0]),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Reassembly slots are only overwritten, never cleared between packets.
  for (genvar gi = 0; gi < MAX_FLITS; gi++) begin : g_slot
    logic [DATA_W-1:0] slot_reg;
    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) slot_reg <= '0;
      else if (slot_we && cnt_reg == LEN_W'(gi)) slot_reg <= head[DATA_MSB:DATA_LSB];
    end
    assign pkt_if.pkt_data[gi*DATA_W +: DATA_W] = slot_reg;
  end

  assign pkt_if.pkt_len   = pkt_len_reg;
  assign pkt_if.pkt_valid = pkt_valid_reg;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      pkt_len_reg   <= '0;
      pkt_valid_reg <= 1'b0;
      send_credit   <= 1'b0;
      credit_out    <= '0;
      err_overflow  <= 1'b0;
      err_oversize  <= 1'b0;
      err_misroute  <= 1'b0;
    end else begin
      send_credit <= pop;
      credit_out  <= pop ? {1'b1, head_vc} : '0;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      if (flit_valid && fifo_full && !pop) err_overflow <= 1'b1;
      case (state_reg)
        COLLECT: if (pop) begin
          if (!dest_ok) begin
            err_misroute <= 1'b1;
            if (head_tail) cnt_reg <= '0;
          end else if (head_tail) begin
            pkt_len_reg   <= cnt_reg + 1'b1;
            pkt_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end else if (cnt_reg == LEN_W'(MAX_FLITS - 1)) begin
            err_oversize <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= DROP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: if (pkt_if.pkt_ready) begin
          pkt_valid_reg <= 1'b0;
          cnt_reg       <= '0;
          state_reg     <= COLLECT;
        end
        DROP: if (pop && head_tail) begin
          cnt_reg   <= '0;
          state_reg <= COLLECT;
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_rx_depacketizer.sv
// Scoreboard bench for noc_rx_depacketizer: directed scenarios plus
// credit-flow-controlled random traffic against a packet-level model.
module tb_noc_rx_depacketizer;
  localparam int DATA_W = 64, MAX_FLITS = 12, FIFO_DEPTH = 8;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic [72:0] flit_in = '0;
  logic        send_credit;
  logic [2:0]  credit_out;
  logic [4:0]  processor_id = 5'd3;
  logic        err_overflow, err_oversize, err_misroute;

  noc_rx_depacketizer_if #(.DATA_W(DATA_W), .MAX_FLITS(MAX_FLITS), .LEN_W(4)) pkt_if ();

  noc_rx_depacketizer #(.DATA_W(DATA_W), .MAX_FLITS(MAX_FLITS), .FIFO_DEPTH(FIFO_DEPTH), .VC_W(2)) u_dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .flit_in      (flit_in),
    .send_credit  (send_credit),
    .credit_out   (credit_out),
    .processor_id (processor_id),
    .pkt_if       (pkt_if),
    .err_overflow (err_overflow),
    .err_oversize (err_oversize),
    .err_misroute (err_misroute)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int                          len;
    logic [MAX_FLITS*DATA_W-1:0] data;
  } pkt_t;

  pkt_t       exp_pkt_q[$];
  logic [1:0] exp_vc_q[$];
  int         pkt_cyc_q[$];
  int         credit_cyc_q[$];
  logic [MAX_FLITS*DATA_W-1:0] cur_data = '0;
  int cur_len = 0;
  int errors = 0, checks = 0;
  int sent = 0, returned = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: accepted flits are grouped by tail; groups longer than
  // MAX_FLITS vanish, misrouted words are skipped; every accepted flit earns a credit.
  task automatic model_flit(input bit tail, input logic [1:0] vc, input logic [63:0] data,
                            input logic [4:0] dest, input bit accept);
    pkt_t p;
    if (!accept) return;
    sent++;
    exp_vc_q.push_back(vc);
`ifdef NOC_RX_DEST_CHECK_EN
    if (dest != processor_id) begin
      if (tail) cur_len = 0;
      return;
    end
`else
    if (dest != dest) return;
`endif
    if (cur_len < MAX_FLITS) cur_data[cur_len*DATA_W +: DATA_W] = data;
    cur_len++;
    if (tail) begin
      if (cur_len <= MAX_FLITS) begin
        p.len  = cur_len;
        p.data = cur_data;
        exp_pkt_q.push_back(p);
      end
      cur_len = 0;
    end
  endtask

  task automatic drive_flit(input bit tail, input logic [1:0] vc, input logic [63:0] data,
                            input logic [4:0] dest, input bit accept);
    flit_in = {1'b1, tail, dest, vc, data};
    model_flit(tail, vc, data, dest, accept);
  endtask

  task automatic send_flit(input bit tail, input logic [1:0] vc, input logic [63:0] data,
                           input logic [4:0] dest, input bit accept);
    @(posedge sys_clk); #1;
    drive_flit(tail, vc, data, dest, accept);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
      flit_in = '0;
    end
  endtask

  task automatic clear_windows();
    pkt_cyc_q.delete();
    credit_cyc_q.delete();
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // Monitor: pops the scoreboards whenever the DUT presents a credit or a packet.
  initial forever begin
    @(negedge sys_clk);
    if (!reset) begin
      if (send_credit) begin
        returned++;
        credit_cyc_q.push_back(cyc);
        $display("cycle %0d credit %b", cyc, credit_out);
        if (exp_vc_q.size() == 0) check("unexpected_credit", {61'd0, credit_out}, 64'd0);
        else check("credit_out", {61'd0, credit_out}, {61'd0, 1'b1, exp_vc_q.pop_front()});
      end
      if (pkt_if.pkt_valid && pkt_if.pkt_ready) begin
        pkt_t p;
        pkt_cyc_q.push_back(cyc);
        $display("cycle %0d packet len=%0d word0=%0h", cyc, pkt_if.pkt_len, pkt_if.pkt_data[63:0]);
        if (exp_pkt_q.size() == 0) begin
          check("unexpected_packet", {60'd0, pkt_if.pkt_len}, 64'd0);
        end else begin
          p = exp_pkt_q.pop_front();
          check("pkt_len", {60'd0, pkt_if.pkt_len}, 64'(p.len));
          for (int k = 0; k < p.len; k++)
            check("pkt_word", pkt_if.pkt_data[k*DATA_W +: DATA_W], p.data[k*DATA_W +: DATA_W]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t, r, n;
    bit done;
    pkt_if.pkt_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_send_credit", {63'd0, send_credit}, 64'd0);
    check("rst_credit_out", {61'd0, credit_out}, 64'd0);
    check("rst_pkt_valid", {63'd0, pkt_if.pkt_valid}, 64'd0);
    check("rst_pkt_len", {60'd0, pkt_if.pkt_len}, 64'd0);
    check("rst_pkt_data", {63'd0, |pkt_if.pkt_data}, 64'd0);
    check("rst_errors", {61'd0, err_overflow, err_oversize, err_misroute}, 64'd0);
    check("rst_fifo_count", 64'(u_dut.fifo_count), 64'd0);
    @(posedge sys_clk); #1;
    reset = 1'b0;
    idle(2);

    // 3-flit packet: latency and credit timing
    pkt_if.pkt_ready = 1'b1;
    clear_windows();
    send_flit(0, 2'd0, 64'h1111, 5'd3, 1); c0 = cyc;
    send_flit(0, 2'd0, 64'h2222, 5'd3, 1);
    send_flit(1, 2'd0, 64'h3333, 5'd3, 1); t = cyc;
    idle(6);
    check("t1_pkt_count", 64'(pkt_cyc_q.size()), 64'd1);
    if (pkt_cyc_q.size() > 0) check("t1_pkt_cycle", 64'(pkt_cyc_q[0]), 64'(t + 2));
    check("t1_credit_count", 64'(credit_cyc_q.size()), 64'd3);
    if (credit_cyc_q.size() == 3) begin
      check("t1_credit0_cycle", 64'(credit_cyc_q[0]), 64'(c0 + 2));
      check("t1_credit2_cycle", 64'(credit_cyc_q[2]), 64'(t + 2));
    end

    // Two back-to-back 2-flit packets on vc 2 with the consumer stalled
    pkt_if.pkt_ready = 1'b0;
    clear_windows();
    send_flit(0, 2'd2, 64'hA1, 5'd3, 1);
    send_flit(1, 2'd2, 64'hA2, 5'd3, 1);
    send_flit(0, 2'd2, 64'hB1, 5'd3, 1);
    send_flit(1, 2'd2, 64'hB2, 5'd3, 1);
    idle(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("hold_valid", {63'd0, pkt_if.pkt_valid}, 64'd1);
      check("hold_len", {60'd0, pkt_if.pkt_len}, 64'd2);
      check("hold_word0", pkt_if.pkt_data[63:0], 64'hA1);
      check("hold_word1", pkt_if.pkt_data[127:64], 64'hA2);
    end
    check("hold_credit_count", 64'(credit_cyc_q.size()), 64'd2);
    check("hold_fifo_count", 64'(u_dut.fifo_count), 64'd2);
    @(posedge sys_clk); #1;
    pkt_if.pkt_ready = 1'b1; r = cyc;
    idle(8);
    check("b2b_pkt_count", 64'(pkt_cyc_q.size()), 64'd2);
    if (pkt_cyc_q.size() == 2) begin
      check("b2b_first_cycle", 64'(pkt_cyc_q[0]), 64'(r));
      check("b2b_gap", 64'(pkt_cyc_q[1] - pkt_cyc_q[0]), 64'd3);
    end
    check("b2b_credit_count", 64'(credit_cyc_q.size()), 64'd4);

    // 13-flit packet exceeds MAX_FLITS, then a 1-flit packet
    clear_windows();
    for (int i = 0; i < 13; i++)
      send_flit(i == 12, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 5'd3, 1);
    send_flit(1, 2'd1, 64'hC0FFEE, 5'd3, 1);
    idle(10);
    check("oversize_flag", {63'd0, err_oversize}, 64'd1);
    check("oversize_credits", 64'(credit_cyc_q.size()), 64'd14);
    check("oversize_pkt_count", 64'(pkt_cyc_q.size()), 64'd1);

`ifdef NOC_RX_DEST_CHECK_EN
    clear_windows();
    send_flit(1, 2'd0, 64'hBAD, 5'd5, 1);
    send_flit(1, 2'd1, 64'h600D, 5'd3, 1);
    idle(8);
    check("misroute_flag", {63'd0, err_misroute}, 64'd1);
    check("misroute_credits", 64'(credit_cyc_q.size()), 64'd2);
    check("misroute_pkt_count", 64'(pkt_cyc_q.size()), 64'd1);
`else
    check("misroute_tied", {63'd0, err_misroute}, 64'd0);
`endif

    // Random traffic paced by credits, random consumer backpressure
    for (int i = 0; i < 400; i++) begin
      @(posedge sys_clk); #1;
      pkt_if.pkt_ready = 1'($urandom_range(0, 1));
      if ((FIFO_DEPTH - (sent - returned)) > 0 && $urandom_range(0, 2) != 0)
        drive_flit($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 5'd3, 1);
      else
        flit_in = '0;
    end
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge sys_clk); #1;
      if ((FIFO_DEPTH - (sent - returned)) > 0) begin
        drive_flit(1, 2'd3, 64'hE0D, 5'd3, 1);
        done = 1'b1;
      end else flit_in = '0;
    end
    pkt_if.pkt_ready = 1'b1;
    n = 0;
    while ((exp_pkt_q.size() != 0 || exp_vc_q.size() != 0) && n < 300) begin
      idle(1);
      n++;
    end
    check("drain_timeout", 64'(n < 300), 64'd1);
    check("random_no_overflow", {63'd0, err_overflow}, 64'd0);

    // Overflow: packet held, nine non-tail flits into an eight-entry FIFO
    pkt_if.pkt_ready = 1'b0;
    send_flit(1, 2'd0, 64'h0F0F, 5'd3, 1);
    idle(3);
    for (int i = 0; i < 9; i++) send_flit(0, 2'd1, 64'(i), 5'd3, i < 8);
    idle(2);
    check("overflow_flag", {63'd0, err_overflow}, 64'd1);
    check("overflow_fifo_count", 64'(u_dut.fifo_count), 64'd8);

    // Reset clears the sticky flags and discards the buffered flits
    @(posedge sys_clk); #1;
    reset = 1'b1;
    exp_pkt_q.delete(); exp_vc_q.delete();
    cur_len = 0; sent = 0; returned = 0;
    repeat (2) @(posedge sys_clk); #1;
    reset = 1'b0;
    idle(3);
    @(negedge sys_clk);
    check("post_rst_errors", {61'd0, err_overflow, err_oversize, err_misroute}, 64'd0);
    check("post_rst_pkt_valid", {63'd0, pkt_if.pkt_valid}, 64'd0);
    check("post_rst_fifo_count", 64'(u_dut.fifo_count), 64'd0);
    check("post_rst_no_credit", 64'(returned), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
